// File: rtl/lampFPU_pkg.sv
// Shared LAMP FPU constants, the integer-to-float stage records, and the
// round-to-nearest-even helper used by the integer-to-bf16 path.
package lampFPU_pkg;

    localparam int LAMP_INTEGER_DW  = 32;
    localparam int LAMP_FLOAT_E_DW  = 8;
    localparam int LAMP_FLOAT_F_DW  = 7;
    localparam int LAMP_FLOAT_E_BIAS = 127;
    localparam int LAMP_FLOAT_DW    = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;
    localparam int LAMP_LZC_W       = $clog2(LAMP_INTEGER_DW);

    typedef struct packed {
        logic                       sign;
        logic                       zero;
        logic [LAMP_INTEGER_DW-1:0] mag;
    } i2f_s1_t;

    typedef struct packed {
        logic                       sign;
        logic                       zero;
        logic [LAMP_FLOAT_E_DW-1:0] exp;
        logic [LAMP_INTEGER_DW-1:0] m;
    } i2f_s2_t;

    typedef struct packed {
        logic [LAMP_FLOAT_DW-1:0] res;
        logic                     inexact;
    } i2f_s3_t;

    // Returns {carry, frac}; carry set means the fraction wrapped to zero.
    function automatic logic [LAMP_FLOAT_F_DW:0] FUNC_i2f_rne(
        input logic [LAMP_FLOAT_F_DW-1:0] frac,
        input logic                       guard,
        input logic                       sticky
    );
        logic round_up;
        round_up = guard & (sticky | frac[0]);
        return {1'b0, frac} + {{LAMP_FLOAT_F_DW{1'b0}}, round_up};
    endfunction

endpackage

// File: rtl/lamp_fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH-1,
// callers track the zero case themselves.
module lamp_fpu_lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Scan from LSB upward so the highest set bit wins last.
    always_comb begin
        cnt_o = CNT_W'(WIDTH - 1);
        for (int i = 0; i < WIDTH; i++) begin
            cnt_o = data_i[i] ? CNT_W'(WIDTH - 1 - i) : cnt_o;
        end
    end

endmodule

// File: rtl/lamp_fpu_i2f_pipe.sv
// Three-stage 32-bit integer to bf16 converter (capture, normalize,
// round/pack) with valid/ready backpressure and RNE rounding.
module lamp_fpu_i2f_pipe
    import lampFPU_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       doI2f_i,
    output logic                       ready_o,
    input  logic [LAMP_INTEGER_DW-1:0] op_i,
    input  logic                       isSigned_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [LAMP_FLOAT_DW-1:0]   res_o,
    output logic                       isInexact_o
);

    localparam logic [LAMP_FLOAT_E_DW-1:0] EXP_TOP =
        LAMP_FLOAT_E_DW'(LAMP_FLOAT_E_BIAS + LAMP_INTEGER_DW - 1);

    logic    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    i2f_s1_t s1_q, s1_d;
    i2f_s2_t s2_q, s2_d;
    i2f_s3_t s3_q, s3_d;

    logic                       en1_s, en2_s, en3_s;
    logic                       accept_s;
    logic                       sign_s;
    logic [LAMP_LZC_W-1:0]      lzc_s;
    logic [LAMP_FLOAT_F_DW:0]   rne_s;
    logic [LAMP_FLOAT_E_DW-1:0] exp_rnd_s;

    // Enable chain: a stage may advance when it is empty or its successor advances.
    always_comb begin
        en3_s    = ~v3_q | ready_i;
        en2_s    = ~v2_q | en3_s;
        en1_s    = ~v1_q | en2_s;
        accept_s = doI2f_i & en1_s & ~rst;
    end

    assign ready_o = en1_s & ~rst;

    // Valid bits follow upstream when enabled, otherwise hold.
    always_comb begin
        v1_d = en1_s ? accept_s : v1_q;
        v2_d = en2_s ? v1_q     : v2_q;
        v3_d = en3_s ? v2_q     : v3_q;
    end

    // Stage 1: sign and magnitude; -2^31 maps naturally to 0x8000_0000.
    always_comb begin
        s1_d   = s1_q;
        sign_s = isSigned_i & op_i[LAMP_INTEGER_DW-1];
        if (accept_s) begin
            s1_d.sign = sign_s;
            s1_d.zero = (op_i == {LAMP_INTEGER_DW{1'b0}});
            s1_d.mag  = sign_s ? (~op_i + {{(LAMP_INTEGER_DW-1){1'b0}}, 1'b1}) : op_i;
        end else begin
            s1_d = s1_q;
        end
    end

    lamp_fpu_lzc #(
        .WIDTH (LAMP_INTEGER_DW),
        .CNT_W (LAMP_LZC_W)
    ) u_lzc (
        .data_i (s1_q.mag),
        .cnt_o  (lzc_s)
    );

    // Stage 2: normalize so the leading one sits at bit 31.
    always_comb begin
        s2_d = s2_q;
        if (en2_s & v1_q) begin
            s2_d.sign = s1_q.sign;
            s2_d.zero = s1_q.zero;
            s2_d.exp  = EXP_TOP - {{(LAMP_FLOAT_E_DW-LAMP_LZC_W){1'b0}}, lzc_s};
            s2_d.m    = s1_q.mag << lzc_s;
        end else begin
            s2_d = s2_q;
        end
    end

    // Stage 3: round to nearest even; a fraction carry bumps the exponent (max 159).
    always_comb begin
        s3_d      = s3_q;
        rne_s     = FUNC_i2f_rne(s2_q.m[30:24], s2_q.m[23], |s2_q.m[22:0]);
        exp_rnd_s = s2_q.exp + {{(LAMP_FLOAT_E_DW-1){1'b0}}, rne_s[LAMP_FLOAT_F_DW]};
        if (en3_s & v2_q) begin
            // A normalized nonzero magnitude always has bit 31 set.
            if (s2_q.zero | ~s2_q.m[31]) begin
                s3_d.res     = {LAMP_FLOAT_DW{1'b0}};
                s3_d.inexact = 1'b0;
            end else begin
                s3_d.res     = {s2_q.sign, exp_rnd_s, rne_s[LAMP_FLOAT_F_DW-1:0]};
                s3_d.inexact = s2_q.m[23] | (|s2_q.m[22:0]);
            end
        end else begin
            s3_d = s3_q;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign valid_o     = v3_q;
    assign res_o       = s3_q.res;
    assign isInexact_o = s3_q.inexact;

endmodule

// File: tb/tb_lamp_fpu_i2f_pipe.sv
// Directed bench for lamp_fpu_i2f_pipe: conversions, latency, backpressure
// and mid-stream reset, with hand-computed bf16 results.
module tb_lamp_fpu_i2f_pipe;

    logic        clk;
    logic        rst;
    logic        doI2f_i;
    logic        ready_o;
    logic [31:0] op_i;
    logic        isSigned_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] res_o;
    logic        isInexact_o;

    int n_tests;
    int n_fail;

    lamp_fpu_i2f_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .doI2f_i     (doI2f_i),
        .ready_o     (ready_o),
        .op_i        (op_i),
        .isSigned_i  (isSigned_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .res_o       (res_o),
        .isInexact_o (isInexact_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Output collector: records every handshaken result.
    logic        collect;
    logic [15:0] got_res[$];
    logic        got_inx[$];

    always @(negedge clk) begin
        if (collect && !rst && valid_o && ready_i) begin
            got_res.push_back(res_o);
            got_inx.push_back(isInexact_o);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        int waited;
        waited = 0;
        while (got_res.size() < n && waited < 60) begin
            step();
            waited++;
        end
        repeat (4) step();
        check_eq("drain_count", got_res.size(), n);
    endtask

    // Directed conversion vectors.
    localparam int NV = 13;
    logic [31:0] v_op  [NV] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000,
                                32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0101, 32'h0000_0103,
                                32'h0000_0180, 32'h0000_0102, 32'h7FFF_FFFF, 32'hFFFF_FEFF,
                                32'h0000_0000};
    logic        v_sgn [NV] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] v_res [NV] = '{16'h3F80, 16'hBF80, 16'h0000, 16'hCF00, 16'h4F00, 16'h4F80,
                                16'h4380, 16'h4382, 16'h43C0, 16'h4381, 16'h4F00, 16'hC380,
                                16'h0000};
    logic        v_inx [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    localparam int NB = 5;
    logic [31:0] b_op  [NB] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0180, 32'h0000_0101, 32'h8000_0000};
    logic        b_sgn [NB] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] b_res [NB] = '{16'h3F80, 16'hBF80, 16'h43C0, 16'h4380, 16'h4F00};
    logic        b_inx [NB] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int  lat;
        int  idx;
        logic acc;
        n_tests    = 0;
        n_fail     = 0;
        collect    = 1'b0;
        rst        = 1'b1;
        doI2f_i    = 1'b0;
        op_i       = 32'h0;
        isSigned_i = 1'b0;
        ready_i    = 1'b1;

        // Reset state.
        repeat (2) step();
        check_eq("rst_valid", valid_o, 1'b0);
        check_eq("rst_res", res_o, 16'h0000);
        check_eq("rst_inx", isInexact_o, 1'b0);
        check_eq("rst_ready", ready_o, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", ready_o, 1'b1);

        // Single-operand latency: the accepting edge counts as the first.
        doI2f_i = 1'b1; op_i = 32'h1; isSigned_i = 1'b1;
        step();
        doI2f_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 10) begin
            step();
            lat++;
        end
        check_eq("latency", lat, 3);
        check_eq("lat_res", res_o, 16'h3F80);
        check_eq("lat_inx", isInexact_o, 1'b0);
        step();
        check_eq("lat_single", valid_o, 1'b0);

        // Back-to-back directed vectors at full throughput.
        got_res.delete(); got_inx.delete();
        collect = 1'b1;
        for (int i = 0; i < NV; i++) begin
            doI2f_i = 1'b1; op_i = v_op[i]; isSigned_i = v_sgn[i];
            #1;
            check_eq($sformatf("stream_ready_%0d", i), ready_o, 1'b1);
            step();
        end
        doI2f_i = 1'b0;
        drain(NV);
        for (int i = 0; i < NV && i < got_res.size(); i++) begin
            check_eq($sformatf("vec_res_%0d", i), got_res[i], v_res[i]);
            check_eq($sformatf("vec_inx_%0d", i), got_inx[i], v_inx[i]);
        end

        // Backpressure: ready_i low for six cycles while five operands are offered.
        got_res.delete(); got_inx.delete();
        idx = 0;
        for (int c = 0; c < 40 && idx < NB; c++) begin
            ready_i = (c >= 6);
            doI2f_i = 1'b1; op_i = b_op[idx]; isSigned_i = b_sgn[idx];
            #1;
            if (c == 3) check_eq("bp_full_ready", ready_o, 1'b0);
            if (c >= 3 && c < 6) begin
                check_eq($sformatf("bp_hold_valid_%0d", c), valid_o, 1'b1);
                check_eq($sformatf("bp_hold_res_%0d", c), res_o, b_res[0]);
                check_eq($sformatf("bp_hold_inx_%0d", c), isInexact_o, b_inx[0]);
            end
            if (c == 6) check_eq("bp_full_accept", ready_o, 1'b1);
            acc = ready_o;
            step();
            if (acc) idx++;
        end
        doI2f_i = 1'b0;
        check_eq("bp_accepted", idx, NB);
        drain(NB);
        for (int i = 0; i < NB && i < got_res.size(); i++) begin
            check_eq($sformatf("bp_res_%0d", i), got_res[i], b_res[i]);
            check_eq($sformatf("bp_inx_%0d", i), got_inx[i], b_inx[i]);
        end

        // Reset with two entries in flight (stages 2 and 3).
        got_res.delete(); got_inx.delete();
        ready_i = 1'b1;
        doI2f_i = 1'b1; op_i = 32'h0000_0180; isSigned_i = 1'b1;
        step();
        op_i = 32'hFFFF_FFFF;
        step();
        doI2f_i = 1'b0;
        step();
        check_eq("mid_pre_valid", valid_o, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", valid_o, 1'b0);
        check_eq("mid_rst_ready", ready_o, 1'b0);
        check_eq("mid_rst_res", res_o, 16'h0000);
        repeat (2) step();
        rst = 1'b0;
        repeat (5) step();
        check_eq("mid_no_emit", got_res.size(), 0);

        doI2f_i = 1'b1; op_i = 32'h0000_0102; isSigned_i = 1'b0;
        #1;
        check_eq("post_rst_ready", ready_o, 1'b1);
        step();
        doI2f_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 10) begin
            step();
            lat++;
        end
        check_eq("post_rst_latency", lat, 3);
        check_eq("post_rst_res", res_o, 16'h4381);
        check_eq("post_rst_inx", isInexact_o, 1'b0);

        collect = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
